// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and helpers for the sync_ram_dp storage primitive
//
// Purpose : clear-engine state encoding and the byte-lane merge used by both the
//           array write path and the read-during-write bypass.
// Contents: MAX_DW       - widest word the merge helper handles
//           clr_state_t  - CLEAR (engine running) / READY (normal operation)
//           byte_merge() - take byte lanes of new_w where be is set, else old_w
package ram_pkg;

   localparam int MAX_DW = 256;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

   // Callers zero-extend narrower words into MAX_DW and slice the result back.
   function automatic logic [MAX_DW-1:0] byte_merge(
      input logic [MAX_DW-1:0]   old_w,
      input logic [MAX_DW-1:0]   new_w,
      input logic [MAX_DW/8-1:0] be
   );
      logic [MAX_DW-1:0] r;
      r = old_w;
      for (int i = 0; i < MAX_DW/8; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - valid/data delay line with hold-on-invalid output
//
// Purpose : adds DEPTH register stages behind the registered array read. A data
//           stage only loads when its incoming valid is set, so the output word
//           holds its last result while no read is in flight.
// Ports   : clk, rst_n       - clock, asynchronous active-low reset
//           in_valid, in_data  - result entering the delay line
//           out_valid, out_data - result DEPTH cycles later
module ram_rd_pipe #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= '0;
      end else begin
         v[0] <= in_valid;
         if (in_valid) d[0] <= in_data;
         for (int i = 1; i < DEPTH; i++) begin
            v[i] <= v[i-1];
            if (v[i-1]) d[i] <= d[i-1];
         end
      end
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

endmodule

// File: rtl/sync_ram_dp.sv
// rtl/sync_ram_dp.sv - simple-dual-port synchronous RAM with byte enables and clear engine
//
// Purpose : one write port and one read port on a single clock, per-byte write
//           enables, 1- or 2-cycle read latency, selectable same-address
//           read-during-write result, and a post-reset engine that writes
//           CLEAR_VALUE to every word before requests are accepted.
// Ports   : clk, rst_n               - clock, asynchronous active-low reset
//           writeEn, waddr, Din, byteEn - write request, address, data, lane enables
//           read, raddr               - read request and address
//           Dout, DoutValid           - read result and its one-cycle valid strobe
//           initBusy                  - clear engine running, requests ignored
module sync_ram_dp
   import ram_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter int                    ADDR_WIDTH   = 10,
   parameter int                    READ_LATENCY = 1,
   parameter int                    RDW_NEW      = 0,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    writeEn,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   Din,
   input  logic [DATA_WIDTH/8-1:0] byteEn,
   input  logic                    read,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   Dout,
   output logic                    DoutValid,
   output logic                    initBusy
);

   localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int BE_W      = DATA_WIDTH / 8;

   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
      $error("sync_ram_dp: READ_LATENCY must be 1 or 2");
   end
   if (DATA_WIDTH % 8 != 0) begin : g_bad_width
      $error("sync_ram_dp: DATA_WIDTH must be a multiple of 8");
   end
   if (DATA_WIDTH > MAX_DW) begin : g_too_wide
      $error("sync_ram_dp: DATA_WIDTH exceeds ram_pkg::MAX_DW");
   end

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   clr_state_t            state;
   logic [ADDR_WIDTH-1:0] cnt;
   logic                  wr_en, rd_en, same_addr;
   logic                  rd_v;
   logic [DATA_WIDTH-1:0] rd_d;

   // Clear engine: one word per cycle, leaves after writing the last address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         cnt   <= '0;
      end else if (state == CLEAR) begin
         cnt <= cnt + 1'b1;
         if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state <= READY;
      end
   end

   assign initBusy  = (state == CLEAR);
   assign wr_en     = (state == READY) && writeEn;
   assign rd_en     = (state == READY) && read;
   assign same_addr = wr_en && rd_en && (waddr == raddr);

   // Words are widened to the helper's fixed width and sliced back afterwards.
   logic [MAX_DW-1:0]   din_x, wold_x, rold_x, wr_x, rdw_x;
   logic [MAX_DW/8-1:0] be_x;

   always_comb begin
      din_x  = '0;
      wold_x = '0;
      rold_x = '0;
      be_x   = '0;
      din_x[DATA_WIDTH-1:0]  = Din;
      wold_x[DATA_WIDTH-1:0] = mem[waddr];
      rold_x[DATA_WIDTH-1:0] = mem[raddr];
      be_x[BE_W-1:0]         = byteEn;
      wr_x  = byte_merge(wold_x, din_x, be_x);
      rdw_x = byte_merge(rold_x, din_x, be_x);
   end

   // Upper lanes of the widened merge results are don't-care.
   logic unused_hi;
   assign unused_hi = ^{wr_x, rdw_x};

   always_ff @(posedge clk) begin
      if (state == CLEAR)  mem[cnt]   <= CLEAR_VALUE;
      else if (wr_en)      mem[waddr] <= wr_x[DATA_WIDTH-1:0];
   end

   // Registered read; the data register only loads on an accepted read so the
   // output holds between results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_v <= 1'b0;
         rd_d <= '0;
      end else begin
         rd_v <= rd_en;
         if (rd_en) rd_d <= (RDW_NEW != 0 && same_addr) ? rdw_x[DATA_WIDTH-1:0]
                                                        : rold_x[DATA_WIDTH-1:0];
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      ram_rd_pipe #(.DEPTH(1), .WIDTH(DATA_WIDTH)) u_rd_pipe (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (rd_v),
         .in_data   (rd_d),
         .out_valid (DoutValid),
         .out_data  (Dout)
      );
   end else begin : g_lat1
      assign DoutValid = rd_v;
      assign Dout      = rd_d;
   end

endmodule

// File: tb/tb_sync_ram_dp.sv
// tb/tb_sync_ram_dp.sv - scoreboard bench for sync_ram_dp (latency 1/old-data and latency 2/new-data)
module tb_sync_ram_dp;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        writeEn = 1'b0;
   logic [3:0]  waddr = '0;
   logic [31:0] Din = '0;
   logic [3:0]  byteEn = '0;
   logic        read = 1'b0;
   logic [3:0]  raddr = '0;
   logic [31:0] dout1, dout2;
   logic        dv1, dv2, busy1, busy2;

   always #5 clk = ~clk;

   sync_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(1), .RDW_NEW(0),
                 .CLEAR_VALUE(32'hDEADBEEF)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .waddr(waddr), .Din(Din),
      .byteEn(byteEn), .read(read), .raddr(raddr), .Dout(dout1),
      .DoutValid(dv1), .initBusy(busy1));

   sync_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_LATENCY(2), .RDW_NEW(1),
                 .CLEAR_VALUE(32'hDEADBEEF)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .writeEn(writeEn), .waddr(waddr), .Din(Din),
      .byteEn(byteEn), .read(read), .raddr(raddr), .Dout(dout2),
      .DoutValid(dv2), .initBusy(busy2));

   typedef struct {
      logic [31:0] d;
      int          due;
   } exp_t;

   exp_t        q1[$];
   exp_t        q2[$];
   exp_t        e1, e2;
   logic [31:0] model [16];
   int          cyc = 0;
   bit          ready = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every valid result must match the oldest outstanding read,
   // in data and in arrival cycle.
   always @(negedge clk) begin
      if (dv1) begin
         n_tests++;
         if (q1.size() == 0) begin
            n_fail++;
            $display("FAIL dut1_unexpected_valid: Dout=%h with no read pending (cycle %0d)", dout1, cyc);
         end else begin
            e1 = q1.pop_front();
            if (dout1 !== e1.d || cyc !== e1.due) begin
               n_fail++;
               $display("FAIL dut1_read: Dout=%h at cycle %0d, expected %h at cycle %0d", dout1, cyc, e1.d, e1.due);
            end
         end
      end
      if (dv2) begin
         n_tests++;
         if (q2.size() == 0) begin
            n_fail++;
            $display("FAIL dut2_unexpected_valid: Dout=%h with no read pending (cycle %0d)", dout2, cyc);
         end else begin
            e2 = q2.pop_front();
            if (dout2 !== e2.d || cyc !== e2.due) begin
               n_fail++;
               $display("FAIL dut2_read: Dout=%h at cycle %0d, expected %h at cycle %0d", dout2, cyc, e2.d, e2.due);
            end
         end
      end
   end

   // Drives one cycle of requests; when the bench knows the RAM is ready it
   // predicts read results for both instances and updates the model.
   task automatic do_cycle(input bit we, input logic [3:0] wa, input logic [31:0] din,
                           input logic [3:0] be, input bit rd, input logic [3:0] ra);
      exp_t        e;
      logic [31:0] old_w, new_w;
      writeEn = we; waddr = wa; Din = din; byteEn = be; read = rd; raddr = ra;
      if (ready) begin
         if (rd) begin
            old_w = model[ra];
            new_w = old_w;
            if (we && wa == ra)
               for (int i = 0; i < 4; i++) if (be[i]) new_w[8*i +: 8] = din[8*i +: 8];
            e.d = old_w; e.due = cyc + 1; q1.push_back(e);
            e.d = new_w; e.due = cyc + 2; q2.push_back(e);
         end
         if (we)
            for (int i = 0; i < 4; i++) if (be[i]) model[wa][8*i +: 8] = din[8*i +: 8];
      end
      @(posedge clk); #1;
      writeEn = 1'b0; read = 1'b0; byteEn = '0;
   endtask

   task automatic enter_reset();
      rst_n = 1'b0;
      q1.delete();
      q2.delete();
      ready = 1'b0;
      for (int i = 0; i < 16; i++) model[i] = 32'hDEADBEEF;
   endtask

   // Returns, per instance, cycles from release until initBusy was first seen low.
   task automatic wait_clear(input int c0, output int b1, output int b2);
      b1 = -1; b2 = -1;
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         if (b1 < 0 && !busy1) b1 = cyc - c0;
         if (b2 < 0 && !busy2) b2 = cyc - c0;
         if (b1 >= 0 && b2 >= 0) break;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      int c0, b1, b2;
      enter_reset();
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({dout1, dv1, busy1} !== {32'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_dut1: Dout=%h DoutValid=%b initBusy=%b, expected 0/0/1", dout1, dv1, busy1);
      end
      n_tests++;
      if ({dout2, dv2, busy2} !== {32'h0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_dut2: Dout=%h DoutValid=%b initBusy=%b, expected 0/0/1", dout2, dv2, busy2);
      end
      rst_n = 1'b1;
      c0 = cyc;
      do_cycle(1'b1, 4'd3, 32'h12345678, 4'hF, 1'b1, 4'd3);
      wait_clear(c0, b1, b2);
      n_tests++;
      if (b1 !== 16 || b2 !== 16) begin
         n_fail++;
         $display("FAIL clear_busy_cycles: dut1=%0d dut2=%0d, expected 16", b1, b2);
      end
      ready = 1'b1;
   endtask

   task automatic test_clear_readback();
      for (int i = 0; i < 16; i++) do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'(i));
      idle(3);
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) do_cycle(1'b1, 4'(i), 32'(2*i + 1), 4'hF, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'(i));
      idle(3);
   endtask

   task automatic test_byte_en();
      do_cycle(1'b1, 4'd5, 32'h11223344, 4'hF, 1'b0, 4'd0);
      do_cycle(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101, 1'b0, 4'd0);
      do_cycle(1'b1, 4'd9, 32'hFFFFFFFF, 4'b0000, 1'b0, 4'd0);
      do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'd5);
      do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'd9);
      idle(3);
      n_tests++;
      if (model[5] !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL byte_en_model: model=%h, expected 11bb33dd", model[5]);
      end
   endtask

   task automatic test_rdw();
      do_cycle(1'b1, 4'd7, 32'h00000000, 4'hF, 1'b0, 4'd0);
      do_cycle(1'b1, 4'd7, 32'hFFFF0000, 4'b1100, 1'b1, 4'd7);
      do_cycle(1'b1, 4'd6, 32'hCAFEF00D, 4'hF, 1'b1, 4'd7);
      do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'd6);
      do_cycle(1'b1, 4'd7, 32'h00000012, 4'b0001, 1'b1, 4'd5);
      idle(3);
      n_tests++;
      if (dout1 !== 32'h11BB33DD || dout2 !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL rdw_independent: dut1=%h dut2=%h, expected 11bb33dd", dout1, dout2);
      end
   endtask

   task automatic test_reset_mid_clear();
      int c0, b1, b2;
      do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'd1);
      enter_reset();
      #1;
      n_tests++;
      if ({dv1, dv2, busy1, busy2} !== 4'b0011 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_discard: dv=%b%b busy=%b%b Dout=%h/%h, expected dv 00 busy 11 Dout 0",
                  dv1, dv2, busy1, busy2, dout1, dout2);
      end
      idle(2);
      rst_n = 1'b1;
      repeat (9) @(posedge clk);
      #1;
      enter_reset();
      #1;
      n_tests++;
      if ({dv1, dv2, busy1, busy2} !== 4'b0011 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_clear_reset: dv=%b%b busy=%b%b Dout=%h/%h, expected dv 00 busy 11 Dout 0",
                  dv1, dv2, busy1, busy2, dout1, dout2);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      c0 = cyc;
      wait_clear(c0, b1, b2);
      n_tests++;
      if (b1 !== 16 || b2 !== 16) begin
         n_fail++;
         $display("FAIL mid_clear_busy_cycles: dut1=%0d dut2=%0d, expected 16", b1, b2);
      end
      n_tests++;
      if ({dv1, dv2} !== 2'b00 || dout1 !== 32'h0 || dout2 !== 32'h0) begin
         n_fail++;
         $display("FAIL mid_clear_outputs: dv=%b%b Dout=%h/%h, expected 00 and 0", dv1, dv2, dout1, dout2);
      end
      ready = 1'b1;
      for (int i = 0; i < 16; i++) do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'(15 - i));
      idle(3);
   endtask

   task automatic test_hold();
      do_cycle(1'b1, 4'd2, 32'h5, 4'hF, 1'b0, 4'd0);
      do_cycle(1'b0, 4'd0, 32'd0, 4'h0, 1'b1, 4'd2);
      repeat (2) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_tests++;
         if (dout1 !== 32'h5 || dout2 !== 32'h5 || dv1 !== 1'b0 || dv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_idle[%0d]: Dout=%h/%h dv=%b%b, expected 5/5 and 00", k, dout1, dout2, dv1, dv2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_readback();
      test_fill();
      test_byte_en();
      test_rdw();
      test_reset_mid_clear();
      test_hold();
      idle(3);
      n_tests++;
      if (q1.size() != 0 || q2.size() != 0) begin
         n_fail++;
         $display("FAIL missing_results: outstanding dut1=%0d dut2=%0d, expected 0", q1.size(), q2.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
